// File: rtl/ozdefs_pkg.sv
// Shared types and symbol constants for the MAC-to-PHY receive-side lane monitor.
// LTSSM state encoding, ordered-set types and the 8b/10b symbol codes used for framing.
package ozdefs_pkg;

    typedef enum logic [3:0] {
        DETECT_QUIET             = 4'd0,
        DETECT_ACTIVE            = 4'd1,
        POLLING_ACTIVE           = 4'd2,
        POLLING_ACTIVE_START_TS1 = 4'd3,
        POLLING_CONFIG           = 4'd4,
        CONFIG_LINKWIDTH_START   = 4'd5,
        CONFIG_LINKWIDTH_ACCEPT  = 4'd6,
        CONFIG_LANENUM_ACCEPT    = 4'd7,
        CONFIG_COMPLETE          = 4'd8,
        CONFIG_IDLE              = 4'd9,
        L0                       = 4'd10
    } ltssm_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        TS1  = 2'd1,
        TS2  = 2'd2
    } os_type_e;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [7:0] IDLE_D = 8'h00;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac2phy_rcvr_iface_os_framer.sv
// Ordered-set framer: tracks symbol position after COM, captures bytes and
// classifies the set as TS1/TS2 on the cycle its last byte arrives.
module os_framer
    import ozdefs_pkg::*;
#(
    parameter int OS_LEN = 16
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            i_data,
    input  logic                  i_k,
    input  logic                  i_en_n,
    output logic                  o_done,
    output os_type_e              o_type,
    output logic [8*OS_LEN-1:0]   o_set,
    output logic [7:0]            o_link,
    output logic                  o_link_k,
    output logic [7:0]            o_lane,
    output logic                  o_lane_k
);

    localparam int PW = $clog2(OS_LEN);

    logic [PW-1:0]     r_pos;
    logic [PW-1:0]     w_pos_next;
    logic [7:0]        r_byte [OS_LEN-1];
    logic              r_k1;
    logic              r_k2;
    logic              w_com;
    logic              w_store;
    logic              w_last;
    logic [OS_LEN-7:0] w_is_ts1;
    logic [OS_LEN-7:0] w_is_ts2;

    // pos==0 means "not inside a set"; a K symbol past the lane field breaks the set
    always_comb begin
        w_com      = !i_en_n && i_k && (i_data == COM);
        w_store    = !i_en_n && !w_com && (r_pos != '0) && !(i_k && (r_pos >= PW'(3)));
        w_last     = w_store && (r_pos == PW'(OS_LEN - 1));
        w_pos_next = r_pos;
        if (i_en_n) begin
            w_pos_next = '0;
        end else if (w_com) begin
            w_pos_next = PW'(1);
        end else if (r_pos != '0) begin
            if (!w_store || w_last)
                w_pos_next = '0;
            else
                w_pos_next = r_pos + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos <= '0;
            r_k1  <= 1'b0;
            r_k2  <= 1'b0;
            for (int i = 0; i < OS_LEN - 1; i++)
                r_byte[i] <= '0;
        end else begin
            r_pos <= w_pos_next;
            if (w_com)
                r_byte[0] <= i_data;
            for (int i = 1; i < OS_LEN - 1; i++) begin
                if (w_store && (r_pos == PW'(i)))
                    r_byte[i] <= i_data;
            end
            if (w_store && (r_pos == PW'(1)))
                r_k1 <= i_k;
            if (w_store && (r_pos == PW'(2)))
                r_k2 <= i_k;
        end
    end

    // The final byte is classified straight from the input so the set is usable on its arrival edge
    generate
        for (genvar gi = 6; gi < OS_LEN; gi++) begin : g_id
            if (gi == OS_LEN - 1) begin : g_live
                assign w_is_ts1[gi-6] = (i_data == TS1_ID);
                assign w_is_ts2[gi-6] = (i_data == TS2_ID);
            end else begin : g_held
                assign w_is_ts1[gi-6] = (r_byte[gi] == TS1_ID);
                assign w_is_ts2[gi-6] = (r_byte[gi] == TS2_ID);
            end
        end
        for (genvar gi = 0; gi < OS_LEN; gi++) begin : g_set
            if (gi == OS_LEN - 1) begin : g_live
                assign o_set[8*gi +: 8] = i_data;
            end else begin : g_held
                assign o_set[8*gi +: 8] = r_byte[gi];
            end
        end
    endgenerate

    always_comb begin
        o_type = NONE;
        if (&w_is_ts1)
            o_type = TS1;
        else if (&w_is_ts2)
            o_type = TS2;
    end

    assign o_done   = w_last && (o_type != NONE);
    assign o_link   = r_byte[1];
    assign o_link_k = r_k1;
    assign o_lane   = r_byte[2];
    assign o_lane_k = r_k2;

endmodule

// File: rtl/mac2phy_rcvr_iface.sv
// Per-lane TX-stream monitor: counts TS1/TS2 sets, latches proposed link/lane numbers,
// detects configuration completion and measures idle-symbol runs for the LTSSM.
module mac2phy_rcvr_iface
    import ozdefs_pkg::*;
#(
    parameter int OS_LEN       = 16,
    parameter int CFG_TS2_REQ  = 8,
    parameter int IDLE_REQ_MAX = 255
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            txdata,
    input  logic                  txdatak,
    input  logic                  en_n,
    input  logic [3:0]            curr_ltssm_state,
    input  logic                  clr_ts1ctr,
    input  logic                  clr_ts2ctr,
    input  logic                  en_idle_ctr,
    output logic [15:0]           ts1ctr,
    output logic [15:0]           ts2ctr,
    output logic [1:0]            os_now_in_queue,
    output logic [8*OS_LEN-1:0]   rcvrq,
    output logic [7:0]            ts1_linkn,
    output logic [7:0]            ts1_lanen,
    output logic                  link_proposed,
    output logic                  lane_proposed,
    output logic                  config_complete,
    output logic [7:0]            idle_ctr
);

    localparam logic [3:0] RUN_MAX  = 4'(CFG_TS2_REQ);
    localparam logic [7:0] IDLE_SAT = 8'(IDLE_REQ_MAX);

    logic                w_os_done;
    os_type_e            w_os_type;
    logic [8*OS_LEN-1:0] w_os_set;
    logic [7:0]          w_link;
    logic                w_link_k;
    logic [7:0]          w_lane;
    logic                w_lane_k;

    logic [15:0]         r_ts1ctr;
    logic [15:0]         r_ts2ctr;
    os_type_e            r_os_type;
    logic [8*OS_LEN-1:0] r_rcvrq;
    logic [7:0]          r_linkn;
    logic [7:0]          r_lanen;
    logic                r_link_prop;
    logic                r_lane_prop;
    logic [3:0]          r_run;
    logic                r_cfg_done;
    logic [7:0]          r_idle;

    logic                w_got_ts1;
    logic                w_got_ts2;
    logic                w_quiet;
    logic                w_ts2_match;
    logic                w_idle_sym;
    logic [15:0]         w_ts1ctr_next;
    logic [15:0]         w_ts2ctr_next;
    logic [3:0]          w_run_next;
    logic [7:0]          w_idle_next;

    os_framer #(
        .OS_LEN (OS_LEN)
    ) u_framer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_data   (txdata),
        .i_k      (txdatak),
        .i_en_n   (en_n),
        .o_done   (w_os_done),
        .o_type   (w_os_type),
        .o_set    (w_os_set),
        .o_link   (w_link),
        .o_link_k (w_link_k),
        .o_lane   (w_lane),
        .o_lane_k (w_lane_k)
    );

    always_comb begin
        w_got_ts1   = w_os_done && (w_os_type == TS1);
        w_got_ts2   = w_os_done && (w_os_type == TS2);
        w_quiet     = (curr_ltssm_state == DETECT_QUIET);
        w_idle_sym  = !en_n && !txdatak && (txdata == IDLE_D);
        // A TS2 only extends the run when it echoes the link/lane this lane proposed
        w_ts2_match = w_got_ts2 && !w_link_k && !w_lane_k && r_link_prop && r_lane_prop &&
                      (w_link == r_linkn) && (w_lane == r_lanen);

        w_ts1ctr_next = r_ts1ctr;
        if (clr_ts1ctr)
            w_ts1ctr_next = '0;
        else if (w_got_ts1)
            w_ts1ctr_next = sat_inc16(r_ts1ctr);

        w_ts2ctr_next = r_ts2ctr;
        if (clr_ts2ctr)
            w_ts2ctr_next = '0;
        else if (w_got_ts2)
            w_ts2ctr_next = sat_inc16(r_ts2ctr);

        w_run_next = r_run;
        if (w_quiet)
            w_run_next = '0;
        else if (w_ts2_match)
            w_run_next = (r_run == RUN_MAX) ? r_run : r_run + 4'd1;
        else if (w_os_done)
            w_run_next = '0;

        w_idle_next = '0;
        if (en_idle_ctr && w_idle_sym)
            w_idle_next = (r_idle == IDLE_SAT) ? r_idle : r_idle + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts1ctr    <= '0;
            r_ts2ctr    <= '0;
            r_os_type   <= NONE;
            r_rcvrq     <= '0;
            r_linkn     <= PAD;
            r_lanen     <= PAD;
            r_link_prop <= 1'b0;
            r_lane_prop <= 1'b0;
            r_run       <= '0;
            r_cfg_done  <= 1'b0;
            r_idle      <= '0;
        end else begin
            r_ts1ctr <= w_ts1ctr_next;
            r_ts2ctr <= w_ts2ctr_next;
            r_idle   <= w_idle_next;
            r_run    <= w_run_next;
            if (w_os_done) begin
                r_os_type <= w_os_type;
                r_rcvrq   <= w_os_set;
            end
            if (w_quiet) begin
                r_linkn     <= PAD;
                r_lanen     <= PAD;
                r_link_prop <= 1'b0;
                r_lane_prop <= 1'b0;
                r_cfg_done  <= 1'b0;
            end else begin
                if (w_got_ts1 && !w_link_k) begin
                    r_linkn     <= w_link;
                    r_link_prop <= 1'b1;
                end
                if (w_got_ts1 && !w_lane_k) begin
                    r_lanen     <= w_lane;
                    r_lane_prop <= 1'b1;
                end
                if (w_run_next == RUN_MAX)
                    r_cfg_done <= 1'b1;
            end
        end
    end

    assign ts1ctr          = r_ts1ctr;
    assign ts2ctr          = r_ts2ctr;
    assign os_now_in_queue = r_os_type;
    assign rcvrq           = r_rcvrq;
    assign ts1_linkn       = r_linkn;
    assign ts1_lanen       = r_lanen;
    assign link_proposed   = r_link_prop;
    assign lane_proposed   = r_lane_prop;
    assign config_complete = r_cfg_done;
    assign idle_ctr        = r_idle;

endmodule

// File: tb/tb_mac2phy_rcvr_iface.sv
// Directed bench for mac2phy_rcvr_iface: queue-based reference model checked every cycle
// plus hand-computed expectations at each scenario boundary.
module tb_mac2phy_rcvr_iface;
    import ozdefs_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   txdata = 8'h00;
    logic         txdatak = 1'b0;
    logic         en_n = 1'b1;
    logic [3:0]   curr_ltssm_state = 4'd10;
    logic         clr_ts1ctr = 1'b0;
    logic         clr_ts2ctr = 1'b0;
    logic         en_idle_ctr = 1'b0;
    logic [15:0]  ts1ctr;
    logic [15:0]  ts2ctr;
    logic [1:0]   os_now_in_queue;
    logic [127:0] rcvrq;
    logic [7:0]   ts1_linkn;
    logic [7:0]   ts1_lanen;
    logic         link_proposed;
    logic         lane_proposed;
    logic         config_complete;
    logic [7:0]   idle_ctr;

    int n_checks = 0;
    int n_fail   = 0;

    mac2phy_rcvr_iface dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .txdata           (txdata),
        .txdatak          (txdatak),
        .en_n             (en_n),
        .curr_ltssm_state (curr_ltssm_state),
        .clr_ts1ctr       (clr_ts1ctr),
        .clr_ts2ctr       (clr_ts2ctr),
        .en_idle_ctr      (en_idle_ctr),
        .ts1ctr           (ts1ctr),
        .ts2ctr           (ts2ctr),
        .os_now_in_queue  (os_now_in_queue),
        .rcvrq            (rcvrq),
        .ts1_linkn        (ts1_linkn),
        .ts1_lanen        (ts1_lanen),
        .link_proposed    (link_proposed),
        .lane_proposed    (lane_proposed),
        .config_complete  (config_complete),
        .idle_ctr         (idle_ctr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   q_d[$];
    logic         q_k[$];
    int           m_ts1 = 0;
    int           m_ts2 = 0;
    int           m_run = 0;
    int           m_idle = 0;
    logic [1:0]   m_type = 2'd0;
    logic [127:0] m_rcvrq = '0;
    logic [7:0]   m_linkn = 8'hF7;
    logic [7:0]   m_lanen = 8'hF7;
    logic         m_lp = 1'b0;
    logic         m_lanep = 1'b0;
    logic         m_cc = 1'b0;

    task automatic model_reset();
        q_d.delete();
        q_k.delete();
        m_ts1 = 0; m_ts2 = 0; m_run = 0; m_idle = 0;
        m_type = 2'd0; m_rcvrq = '0;
        m_linkn = 8'hF7; m_lanen = 8'hF7;
        m_lp = 1'b0; m_lanep = 1'b0; m_cc = 1'b0;
    endtask

    task automatic model_step();
        bit         done = 1'b0;
        logic [1:0] typ = 2'd0;
        logic [7:0] b1 = 8'h00;
        logic [7:0] b2 = 8'h00;
        logic       k1 = 1'b0;
        logic       k2 = 1'b0;
        bit         all1 = 1'b1;
        bit         all2 = 1'b1;

        if (!en_idle_ctr)
            m_idle = 0;
        else if (!en_n && !txdatak && txdata == 8'h00)
            m_idle = (m_idle < 255) ? m_idle + 1 : 255;
        else
            m_idle = 0;

        if (en_n) begin
            q_d.delete(); q_k.delete();
        end else if (txdatak && txdata == 8'hBC) begin
            q_d = {8'hBC}; q_k = {1'b1};
        end else if (q_d.size() > 0) begin
            if (txdatak && q_d.size() >= 3) begin
                q_d.delete(); q_k.delete();
            end else begin
                q_d.push_back(txdata);
                q_k.push_back(txdatak);
                if (q_d.size() == 16) begin
                    for (int i = 6; i < 16; i++) begin
                        all1 &= (q_d[i] == 8'h4A);
                        all2 &= (q_d[i] == 8'h45);
                    end
                    if (all1 || all2) begin
                        done = 1'b1;
                        typ  = all1 ? 2'd1 : 2'd2;
                        b1 = q_d[1]; b2 = q_d[2]; k1 = q_k[1]; k2 = q_k[2];
                        for (int i = 0; i < 16; i++)
                            m_rcvrq[8*i +: 8] = q_d[i];
                        m_type = typ;
                    end
                    q_d.delete(); q_k.delete();
                end
            end
        end

        if (clr_ts1ctr) m_ts1 = 0;
        else if (done && typ == 2'd1 && m_ts1 < 65535) m_ts1++;
        if (clr_ts2ctr) m_ts2 = 0;
        else if (done && typ == 2'd2 && m_ts2 < 65535) m_ts2++;

        if (curr_ltssm_state == 4'd0) begin
            m_run = 0; m_cc = 1'b0; m_lp = 1'b0; m_lanep = 1'b0;
            m_linkn = 8'hF7; m_lanen = 8'hF7;
        end else if (done) begin
            if (typ == 2'd2 && !k1 && !k2 && m_lp && m_lanep && b1 == m_linkn && b2 == m_lanen) begin
                if (m_run < 8) m_run++;
                if (m_run == 8) m_cc = 1'b1;
            end else begin
                m_run = 0;
            end
            if (typ == 2'd1 && !k1) begin m_linkn = b1; m_lp = 1'b1; end
            if (typ == 2'd1 && !k2) begin m_lanen = b2; m_lanep = 1'b1; end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("cyc_ts1ctr", 128'(ts1ctr), 128'(m_ts1));
            chk("cyc_ts2ctr", 128'(ts2ctr), 128'(m_ts2));
            chk("cyc_os_type", 128'(os_now_in_queue), 128'(m_type));
            chk("cyc_rcvrq", rcvrq, m_rcvrq);
            chk("cyc_linkn", 128'(ts1_linkn), 128'(m_linkn));
            chk("cyc_lanen", 128'(ts1_lanen), 128'(m_lanen));
            chk("cyc_link_prop", 128'(link_proposed), 128'(m_lp));
            chk("cyc_lane_prop", 128'(lane_proposed), 128'(m_lanep));
            chk("cyc_cfg_done", 128'(config_complete), 128'(m_cc));
            chk("cyc_idle", 128'(idle_ctr), 128'(m_idle));
        end
    end

    // ---------------- stimulus ----------------
    task automatic sym(input logic [7:0] d, input logic k, input logic e = 1'b0);
        @(negedge clk);
        txdata = d; txdatak = k; en_n = e;
    endtask

    task automatic gap();
        sym(8'h00, 1'b0, 1'b1);
        #1;
    endtask

    task automatic send_os(input logic [7:0] id, input logic [7:0] ln, input logic lk,
                           input logic [7:0] la, input logic lak);
        sym(8'hBC, 1'b1); sym(ln, lk); sym(la, lak);
        sym(8'h10, 1'b0); sym(8'h02, 1'b0); sym(8'h00, 1'b0);
        for (int i = 6; i < 16; i++) sym(id, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ts1ctr"}, 128'(ts1ctr), 128'(0));
        chk({tag, "_ts2ctr"}, 128'(ts2ctr), 128'(0));
        chk({tag, "_os_type"}, 128'(os_now_in_queue), 128'(0));
        chk({tag, "_rcvrq"}, rcvrq, 128'(0));
        chk({tag, "_linkn"}, 128'(ts1_linkn), 128'(8'hF7));
        chk({tag, "_lanen"}, 128'(ts1_lanen), 128'(8'hF7));
        chk({tag, "_flags"}, 128'({link_proposed, lane_proposed, config_complete}), 128'(0));
        chk({tag, "_idle"}, 128'(idle_ctr), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk) reset_n = 1'b1;

        // 20 back-to-back TS1 with PAD link/lane
        repeat (20) send_os(8'h4A, 8'hF7, 1'b1, 8'hF7, 1'b1);
        gap();
        chk("s1_ts1ctr", 128'(ts1ctr), 128'(20));
        chk("s1_link_prop", 128'(link_proposed), 128'(0));
        chk("s1_os_type", 128'(os_now_in_queue), 128'(1));
        chk("s1_com_byte", 128'(rcvrq[7:0]), 128'(8'hBC));
        chk("s1_byte15", 128'(rcvrq[127:120]), 128'(8'h4A));

        // TS1 proposing link 1 / lane 0
        repeat (8) send_os(8'h4A, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s2_props", 128'({link_proposed, lane_proposed}), 128'(2'b11));
        chk("s2_linkn", 128'(ts1_linkn), 128'(8'h01));
        chk("s2_lanen", 128'(ts1_lanen), 128'(8'h00));
        chk("s2_ts1ctr", 128'(ts1ctr), 128'(28));
        @(negedge clk) clr_ts1ctr = 1'b1;
        @(negedge clk) clr_ts1ctr = 1'b0;
        #1 chk("s2_ts1_clear", 128'(ts1ctr), 128'(0));

        // TS2 run, broken once by a lane mismatch
        repeat (4) send_os(8'h45, 8'h01, 1'b0, 8'h00, 1'b0);
        send_os(8'h45, 8'h01, 1'b0, 8'h02, 1'b0);
        repeat (7) send_os(8'h45, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s3_cfg_after7", 128'(config_complete), 128'(0));
        chk("s3_ts2ctr12", 128'(ts2ctr), 128'(12));
        send_os(8'h45, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s3_cfg_after8", 128'(config_complete), 128'(1));
        chk("s3_ts2ctr13", 128'(ts2ctr), 128'(13));
        chk("s3_os_type", 128'(os_now_in_queue), 128'(2));
        @(negedge clk) clr_ts2ctr = 1'b1;
        @(negedge clk) clr_ts2ctr = 1'b0;
        #1 chk("s3_ts2_clear", 128'(ts2ctr), 128'(0));
        send_os(8'h4A, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s3_cfg_sticky", 128'(config_complete), 128'(1));
        chk("s3_ts1ctr1", 128'(ts1ctr), 128'(1));

        // COM restart at symbol 9, then K abort, en_n abort and a discarded set
        sym(8'hBC, 1'b1); sym(8'h01, 1'b0); sym(8'h00, 1'b0); sym(8'h10, 1'b0);
        sym(8'h02, 1'b0); sym(8'h00, 1'b0);
        repeat (3) sym(8'h4A, 1'b0);
        send_os(8'h4A, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s4_restart", 128'(ts1ctr), 128'(2));
        sym(8'hBC, 1'b1); sym(8'h01, 1'b0); sym(8'h00, 1'b0); sym(8'h1C, 1'b1);
        repeat (12) sym(8'h4A, 1'b0);
        gap();
        chk("s4_k_abort", 128'(ts1ctr), 128'(2));
        sym(8'hBC, 1'b1); sym(8'h01, 1'b0); sym(8'h00, 1'b0); sym(8'h10, 1'b0);
        sym(8'h02, 1'b0); sym(8'h00, 1'b0);
        repeat (4) sym(8'h4A, 1'b0);
        sym(8'h4A, 1'b0, 1'b1);
        repeat (5) sym(8'h4A, 1'b0);
        gap();
        chk("s4_en_abort", 128'(ts1ctr), 128'(2));
        sym(8'hBC, 1'b1); sym(8'h07, 1'b0); sym(8'h00, 1'b0); sym(8'h10, 1'b0);
        sym(8'h02, 1'b0); sym(8'h00, 1'b0);
        repeat (9) sym(8'h4A, 1'b0);
        sym(8'h45, 1'b0);
        gap();
        chk("s4_discard_type", 128'(os_now_in_queue), 128'(1));
        chk("s4_discard_link", 128'(rcvrq[15:8]), 128'(8'h01));
        chk("s4_discard_cnt", 128'({ts1ctr, ts2ctr}), 128'({16'd2, 16'd0}));

        // idle counter
        en_idle_ctr = 1'b1;
        repeat (10) sym(8'h00, 1'b0);
        sym(8'hBC, 1'b1); #1;
        chk("s5_idle10", 128'(idle_ctr), 128'(10));
        sym(8'h00, 1'b0); #1;
        chk("s5_idle_com", 128'(idle_ctr), 128'(0));
        repeat (3) sym(8'h00, 1'b0);
        #1 chk("s5_idle3", 128'(idle_ctr), 128'(3));
        en_idle_ctr = 1'b0;
        sym(8'h00, 1'b0); #1;
        chk("s5_idle_dis", 128'(idle_ctr), 128'(0));
        en_idle_ctr = 1'b1;
        repeat (300) sym(8'h00, 1'b0);
        sym(8'hBC, 1'b1); #1;
        chk("s5_idle_sat", 128'(idle_ctr), 128'(255));
        en_idle_ctr = 1'b0;
        gap();

        // DETECT_QUIET clear, then async reset mid-set
        @(negedge clk) curr_ltssm_state = 4'd0;
        @(negedge clk) #1;
        chk("s6_quiet_flags", 128'({link_proposed, lane_proposed, config_complete}), 128'(0));
        chk("s6_quiet_link", 128'({ts1_linkn, ts1_lanen}), 128'(16'hF7F7));
        sym(8'hBC, 1'b1); sym(8'h01, 1'b0); sym(8'h00, 1'b0); sym(8'h10, 1'b0); sym(8'h02, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("s6_async");
        @(negedge clk) reset_n = 1'b1;
        sym(8'h00, 1'b0);
        repeat (10) sym(8'h4A, 1'b0);
        gap();
        chk("s6_drop_partial", 128'(ts1ctr), 128'(0));
        send_os(8'h4A, 8'h01, 1'b0, 8'h00, 1'b0);
        gap();
        chk("s6_quiet_ts1cnt", 128'(ts1ctr), 128'(1));
        chk("s6_quiet_noprop", 128'({link_proposed, lane_proposed}), 128'(0));
        curr_ltssm_state = 4'd10;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
